regfile_wb_queue: RTL and testbench
===================================

// Module: regfile_wb_queue
// PURPOSE
//  Writer side of the 32x32 integer register file's single write port (rd_addr/rd_data/rd_wren).
//  Collects writebacks from the ALU retire path and the load unit, buffers them in order,
//  and drains one per cycle into the register file.
//  Reports in-flight destinations so decode can stall on RAW hazards before the write lands.
// PARAMETERS
//  DEPTH   4   queue entries; power of 2, >= 2
//  DATA_W  32  register data width
//  ADDR_W  5   register address width (32 registers, x0 hardwired zero)
// PORTS
//  clk_i           in   1       clock; all state updates on rising edge
//  rst_i           in   1       reset, synchronous, active-high
//  alu_valid_i     in   1       ALU writeback request
//  alu_ready_o     out  1       ALU request accepted when valid&ready at edge
//  alu_rd_addr_i   in   ADDR_W  ALU destination register
//  alu_rd_data_i   in   DATA_W  ALU result
//  lsu_valid_i     in   1       load-return writeback request
//  lsu_ready_o     out  1       LSU request accepted when valid&ready at edge
//  lsu_rd_addr_i   in   ADDR_W  load destination register
//  lsu_rd_data_i   in   DATA_W  load data
//  wb_stall_i      in   1       1 = hold queue; no drain this cycle
//  rd_addr_o       out  ADDR_W  to register file write address
//  rd_data_o       out  DATA_W  to register file write data
//  rd_wren_o       out  1       to register file write enable
//  rs1_addr_i      in   ADDR_W  decode source 1 address
//  rs2_addr_i      in   ADDR_W  decode source 2 address
//  rs1_pend_o      out  1       rs1 has an unwritten pending write
//  rs2_pend_o      out  1       rs2 has an unwritten pending write
//  count_o         out  $clog2(DEPTH)+1  queued entries (excl. output register)
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pointers, count_o=0, rd_wren_o=0, rd_addr_o=0, rd_data_o=0.
//    Queued entries are discarded; no write issues after reset. Both readys forced 0 while rst_i=1.
//  - Acceptance: one push per cycle. lsu_ready_o = (count_o<DEPTH). alu_ready_o = (count_o<DEPTH) & !lsu_valid_i.
//    LSU wins a same-cycle conflict; ALU must hold its request.
//  - x0 filter: accepted request with addr 0 completes the handshake, is not enqueued, count_o unchanged.
//  - Drain: at each edge with count_o>0 and !wb_stall_i, head pops into rd_* registers with rd_wren_o=1.
//    Otherwise rd_wren_o=0 next cycle; rd_addr_o/rd_data_o hold. rd_wren_o never high for >1 cycle per entry.
//  - Latency: push at edge E into an empty queue -> rd_wren_o=1 in cycle after E+1 -> regfile writes at E+2.
//  - Ordering: strict FIFO; drain order = acceptance order.
//  - Push and pop at one edge: count_o unchanged. Full with pop: ready still 0 that cycle (count-based).
//  - Pointers wrap modulo DEPTH; count_o is the sole full/empty indicator (0..DEPTH).
//  - rsN_pend_o (combinational): rsN_addr_i != 0 and it matches any valid queued entry,
//    or it matches rd_addr_o while rd_wren_o=1. Same-cycle incoming requests are not included.
// CONFIGURATION
//  Macro REGFILE_WB_QUEUE_FWD_EN:
//  - Defined: adds outputs rs1_fwd_data_o/rs2_fwd_data_o [DATA_W] and rs1_fwd_hit_o/rs2_fwd_hit_o.
//    hit = pend; data = youngest matching entry (output register is oldest). Data is 0 when hit=0.
//  - Undefined: these ports and their match-priority logic are absent; pend outputs are unchanged.
// TESTING
//  1 Reset: rst_i=1 for 2 cycles with valids high -> readys 0, count_o=0, rd_wren_o=0. After release, readys=1.
//  2 ALU x5=32'hDEADBEEF, empty queue, no stall -> rd_wren_o=1 for exactly 1 cycle, 2 edges later,
//    with rd_addr_o=5 and data DEADBEEF. rs1_addr_i=5 -> rs1_pend_o=1 from after push through that cycle.
//  3 Same cycle ALU x1=0x11 and LSU x2=0x22 -> lsu accepted, alu_ready_o=0; ALU accepted next cycle.
//    Writes issue in order x2 then x1.
//  4 DEPTH=4, wb_stall_i=1, push x3..x6 -> count_o=4, both readys 0. Drop stall -> 4 back-to-back writes
//    x3,x4,x5,x6; count_o goes 3,2,1,0.
//  5 Push x0 data 32'hFFFF -> ready 1, count_o stays 0, no rd_wren_o; rs1_addr_i=0 -> rs1_pend_o=0.
//    Assert rst_i with 3 entries queued -> no rd_wren_o after the reset edge.
//  6 FWD_EN, stall, push x7=1 then x7=2 -> rs1_addr_i=7: rs1_fwd_hit_o=1, rs1_fwd_data_o=2.
//    After x7=1 drains it stays 2; after both drain, hit=0.

Source files
------------

// File: rtl/regfile_wb_queue.sv
// Ordered writeback queue feeding the register file write port, with RAW pending lookup.
// Define REGFILE_WB_QUEUE_FWD_EN to add youngest-match forwarding outputs.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [ADDR_W-1:0]        alu_rd_addr_i,
  input  logic [DATA_W-1:0]        alu_rd_data_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [ADDR_W-1:0]        lsu_rd_addr_i,
  input  logic [DATA_W-1:0]        lsu_rd_data_i,
  input  logic                     wb_stall_i,
  output logic [ADDR_W-1:0]        rd_addr_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_wren_o,
  input  logic [ADDR_W-1:0]        rs1_addr_i,
  input  logic [ADDR_W-1:0]        rs2_addr_i,
  output logic                     rs1_pend_o,
  output logic                     rs2_pend_o,
`ifdef REGFILE_WB_QUEUE_FWD_EN
  output logic [DATA_W-1:0]        rs1_fwd_data_o,
  output logic [DATA_W-1:0]        rs2_fwd_data_o,
  output logic                     rs1_fwd_hit_o,
  output logic                     rs2_fwd_hit_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              can_push;
  logic              push_lsu;
  logic              push_alu;
  logic              enq;
  logic              pop;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  assign can_push    = !rst_i && (count_o < CNT_W'(DEPTH));
  assign lsu_ready_o = can_push;
  assign alu_ready_o = can_push && !lsu_valid_i;
  assign push_lsu    = lsu_valid_i && lsu_ready_o;
  assign push_alu    = alu_valid_i && alu_ready_o;
  assign in_addr     = push_lsu ? lsu_rd_addr_i : alu_rd_addr_i;
  assign in_data     = push_lsu ? lsu_rd_data_i : alu_rd_data_i;
  // x0 writes finish the handshake but never occupy a slot
  assign enq         = (push_lsu || push_alu) && (in_addr != '0);
  assign pop         = (count_o != '0) && !wb_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_o   <= '0;
      rd_wren_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_o   <= count_o + CNT_W'(enq) - CNT_W'(pop);
      rd_wren_o <= pop;
      if (pop) begin
        rd_addr_o <= q_addr[rd_ptr];
        rd_data_o <= q_data[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
    end
  end

  logic [ADDR_W-1:0] rs_addr [2];
  logic [1:0]        pend;
`ifdef REGFILE_WB_QUEUE_FWD_EN
  logic [DATA_W-1:0] fwd [2];
`endif

  assign rs_addr[0] = rs1_addr_i;
  assign rs_addr[1] = rs2_addr_i;

  // Scan oldest to youngest so the last match is the youngest writer
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      pend[s] = 1'b0;
`ifdef REGFILE_WB_QUEUE_FWD_EN
      fwd[s] = '0;
`endif
      if (rd_wren_o && (rd_addr_o == rs_addr[s])) begin
        pend[s] = 1'b1;
`ifdef REGFILE_WB_QUEUE_FWD_EN
        fwd[s] = rd_data_o;
`endif
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CNT_W'(k) < count_o) &&
            (q_addr[rd_ptr + PTR_W'(k)] == rs_addr[s])) begin
          pend[s] = 1'b1;
`ifdef REGFILE_WB_QUEUE_FWD_EN
          fwd[s] = q_data[rd_ptr + PTR_W'(k)];
`endif
        end
      end
      if (rs_addr[s] == '0) begin
        pend[s] = 1'b0;
`ifdef REGFILE_WB_QUEUE_FWD_EN
        fwd[s] = '0;
`endif
      end
    end
  end

  assign rs1_pend_o = pend[0];
  assign rs2_pend_o = pend[1];
`ifdef REGFILE_WB_QUEUE_FWD_EN
  assign rs1_fwd_hit_o  = pend[0];
  assign rs2_fwd_hit_o  = pend[1];
  assign rs1_fwd_data_o = fwd[0];
  assign rs2_fwd_data_o = fwd[1];
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: expected writes queued at handshake,
// checked in order whenever the DUT raises rd_wren_o.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i, wb_stall_i;
  logic [4:0]  alu_rd_addr_i, lsu_rd_addr_i, rs1_addr_i, rs2_addr_i;
  logic [31:0] alu_rd_data_i, lsu_rd_data_i;
  logic        alu_ready_o, lsu_ready_o, rd_wren_o;
  logic        rs1_pend_o, rs2_pend_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [2:0]  count_o;
`ifdef REGFILE_WB_QUEUE_FWD_EN
  logic [31:0] rs1_fwd_data_o, rs2_fwd_data_o;
  logic        rs1_fwd_hit_o, rs2_fwd_hit_o;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  regfile_wb_queue dut (
    .clk_i(clk), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_rd_addr_i(alu_rd_addr_i), .alu_rd_data_i(alu_rd_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
    .wb_stall_i(wb_stall_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wren_o(rd_wren_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_pend_o(rs1_pend_o), .rs2_pend_o(rs2_pend_o),
`ifdef REGFILE_WB_QUEUE_FWD_EN
    .rs1_fwd_data_o(rs1_fwd_data_o), .rs2_fwd_data_o(rs2_fwd_data_o),
    .rs1_fwd_hit_o(rs1_fwd_hit_o), .rs2_fwd_hit_o(rs2_fwd_hit_o),
`endif
    .count_o(count_o)
  );

  always @(negedge clk) begin
    if (rd_wren_o === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected got x%0d=%h want no write", rd_addr_o, rd_data_o);
      end else begin
        ent_t e;
        e = sb.pop_front();
        if (rd_addr_o !== e.a || rd_data_o !== e.d)
          $display("FAIL sb_write got x%0d=%h want x%0d=%h", rd_addr_o, rd_data_o, e.a, e.d);
        else passed++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; wb_stall_i = 1'b0;
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd1; alu_rd_data_i = 32'h1;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd2; lsu_rd_data_i = 32'h2;
    rs1_addr_i = '0; rs2_addr_i = '0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      total++; if (alu_ready_o !== 1'b0) $display("FAIL rst_alu_rdy got %b want 0", alu_ready_o); else passed++;
      total++; if (lsu_ready_o !== 1'b0) $display("FAIL rst_lsu_rdy got %b want 0", lsu_ready_o); else passed++;
      total++; if (count_o !== 3'd0) $display("FAIL rst_count got %0d want 0", count_o); else passed++;
      total++; if (rd_wren_o !== 1'b0) $display("FAIL rst_wren got %b want 0", rd_wren_o); else passed++;
    end
    next_cycle();
    rst_i = 1'b0; alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    @(negedge clk);
    total++; if (alu_ready_o !== 1'b1) $display("FAIL rel_alu_rdy got %b want 1", alu_ready_o); else passed++;
    total++; if (lsu_ready_o !== 1'b1) $display("FAIL rel_lsu_rdy got %b want 1", lsu_ready_o); else passed++;
  endtask

  task automatic test_single();
    next_cycle();
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd5; alu_rd_data_i = 32'hDEADBEEF; rs1_addr_i = 5'd5;
    @(negedge clk);
    total++; if (alu_ready_o !== 1'b1) $display("FAIL single_rdy got %b want 1", alu_ready_o); else passed++;
    total++; if (rs1_pend_o !== 1'b0) $display("FAIL single_pend0 got %b want 0", rs1_pend_o); else passed++;
    sb.push_back('{a: 5'd5, d: 32'hDEADBEEF});
    next_cycle();
    alu_valid_i = 1'b0;
    @(negedge clk);
    total++; if (rs1_pend_o !== 1'b1) $display("FAIL single_pend1 got %b want 1", rs1_pend_o); else passed++;
    total++; if (rd_wren_o !== 1'b0) $display("FAIL single_wren1 got %b want 0", rd_wren_o); else passed++;
    total++; if (count_o !== 3'd1) $display("FAIL single_cnt got %0d want 1", count_o); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (rd_wren_o !== 1'b1) $display("FAIL single_wren2 got %b want 1", rd_wren_o); else passed++;
    total++; if (rs1_pend_o !== 1'b1) $display("FAIL single_pend2 got %b want 1", rs1_pend_o); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (rd_wren_o !== 1'b0) $display("FAIL single_wren3 got %b want 0", rd_wren_o); else passed++;
    total++; if (rs1_pend_o !== 1'b0) $display("FAIL single_pend3 got %b want 0", rs1_pend_o); else passed++;
  endtask

  task automatic test_arb();
    next_cycle();
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd1; alu_rd_data_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd2; lsu_rd_data_i = 32'h22;
    @(negedge clk);
    total++; if (lsu_ready_o !== 1'b1) $display("FAIL arb_lsu_rdy got %b want 1", lsu_ready_o); else passed++;
    total++; if (alu_ready_o !== 1'b0) $display("FAIL arb_alu_rdy got %b want 0", alu_ready_o); else passed++;
    sb.push_back('{a: 5'd2, d: 32'h22});
    next_cycle();
    lsu_valid_i = 1'b0;
    @(negedge clk);
    total++; if (alu_ready_o !== 1'b1) $display("FAIL arb_alu_rdy2 got %b want 1", alu_ready_o); else passed++;
    sb.push_back('{a: 5'd1, d: 32'h11});
    next_cycle();
    alu_valid_i = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    total++; if (count_o !== 3'd0) $display("FAIL arb_cnt got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_full();
    wb_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      alu_valid_i = 1'b1; alu_rd_addr_i = 5'(3 + i); alu_rd_data_i = 32'h300 + i;
      @(negedge clk);
      total++; if (alu_ready_o !== 1'b1) $display("FAIL full_push%0d got %b want 1", i, alu_ready_o); else passed++;
      sb.push_back('{a: 5'(3 + i), d: 32'h300 + i});
    end
    next_cycle();
    alu_rd_addr_i = 5'd9; lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd10;
    @(negedge clk);
    total++; if (count_o !== 3'd4) $display("FAIL full_cnt got %0d want 4", count_o); else passed++;
    total++; if (alu_ready_o !== 1'b0) $display("FAIL full_alu_rdy got %b want 0", alu_ready_o); else passed++;
    total++; if (lsu_ready_o !== 1'b0) $display("FAIL full_lsu_rdy got %b want 0", lsu_ready_o); else passed++;
    next_cycle();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0; wb_stall_i = 1'b0;
    @(negedge clk);
    total++; if (lsu_ready_o !== 1'b0) $display("FAIL full_pop_rdy got %b want 0", lsu_ready_o); else passed++;
    for (int j = 0; j < 4; j++) begin
      next_cycle();
      @(negedge clk);
      total++; if (count_o !== 3'(3 - j)) $display("FAIL drain_cnt%0d got %0d want %0d", j, count_o, 3 - j); else passed++;
      total++; if (rd_wren_o !== 1'b1) $display("FAIL drain_wren%0d got %b want 1", j, rd_wren_o); else passed++;
    end
    next_cycle();
    @(negedge clk);
    total++; if (rd_wren_o !== 1'b0) $display("FAIL drain_end got %b want 0", rd_wren_o); else passed++;
  endtask

  task automatic test_x0_and_flush();
    next_cycle();
    alu_valid_i = 1'b1; alu_rd_addr_i = 5'd0; alu_rd_data_i = 32'hFFFF; rs1_addr_i = 5'd0;
    @(negedge clk);
    total++; if (alu_ready_o !== 1'b1) $display("FAIL x0_rdy got %b want 1", alu_ready_o); else passed++;
    next_cycle();
    alu_valid_i = 1'b0;
    @(negedge clk);
    total++; if (count_o !== 3'd0) $display("FAIL x0_cnt got %0d want 0", count_o); else passed++;
    total++; if (rs1_pend_o !== 1'b0) $display("FAIL x0_pend got %b want 0", rs1_pend_o); else passed++;
    next_cycle();
    @(negedge clk);
    total++; if (rd_wren_o !== 1'b0) $display("FAIL x0_wren got %b want 0", rd_wren_o); else passed++;
    wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'(8 + i); lsu_rd_data_i = 32'h800 + i;
      sb.push_back('{a: 5'(8 + i), d: 32'h800 + i});
    end
    next_cycle();
    lsu_valid_i = 1'b0; rs2_addr_i = 5'd9;
    @(negedge clk);
    total++; if (count_o !== 3'd3) $display("FAIL flush_cnt got %0d want 3", count_o); else passed++;
    total++; if (rs2_pend_o !== 1'b1) $display("FAIL flush_pend got %b want 1", rs2_pend_o); else passed++;
    next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; wb_stall_i = 1'b0;
    sb.delete();
    @(negedge clk);
    total++; if (count_o !== 3'd0) $display("FAIL flush_cnt0 got %0d want 0", count_o); else passed++;
    total++; if (rs2_pend_o !== 1'b0) $display("FAIL flush_pend0 got %b want 0", rs2_pend_o); else passed++;
    repeat (3) begin
      next_cycle();
      @(negedge clk);
      total++; if (rd_wren_o !== 1'b0) $display("FAIL flush_wren got %b want 0", rd_wren_o); else passed++;
    end
    rs2_addr_i = '0;
  endtask

  task automatic test_random();
    int mcnt = 0;
    for (int c = 0; c < 60; c++) begin
      logic acc, pop;
      logic [4:0] a;
      logic [31:0] d;
      next_cycle();
      alu_valid_i = 1'($urandom_range(0, 1)); alu_rd_addr_i = 5'($urandom_range(0, 7));
      alu_rd_data_i = $urandom;
      lsu_valid_i = ($urandom_range(0, 3) == 0); lsu_rd_addr_i = 5'($urandom_range(0, 7));
      lsu_rd_data_i = $urandom;
      wb_stall_i = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      total++; if (count_o !== 3'(mcnt)) $display("FAIL rnd_cnt got %0d want %0d", count_o, mcnt); else passed++;
      total++; if (lsu_ready_o !== (mcnt < 4)) $display("FAIL rnd_lsu_rdy got %b want %b", lsu_ready_o, mcnt < 4); else passed++;
      total++; if (alu_ready_o !== (mcnt < 4 && !lsu_valid_i)) $display("FAIL rnd_alu_rdy got %b want %b", alu_ready_o, mcnt < 4 && !lsu_valid_i); else passed++;
      acc = (mcnt < 4) && (lsu_valid_i || alu_valid_i);
      a = lsu_valid_i ? lsu_rd_addr_i : alu_rd_addr_i;
      d = lsu_valid_i ? lsu_rd_data_i : alu_rd_data_i;
      pop = (mcnt > 0) && !wb_stall_i;
      if (acc && a != 5'd0) begin
        sb.push_back('{a: a, d: d});
        mcnt++;
      end
      if (pop) mcnt--;
    end
    next_cycle();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0; wb_stall_i = 1'b0;
    repeat (8) next_cycle();
  endtask

`ifdef REGFILE_WB_QUEUE_FWD_EN
  task automatic test_fwd();
    wb_stall_i = 1'b1; rs1_addr_i = 5'd7;
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      alu_valid_i = 1'b1; alu_rd_addr_i = 5'd7; alu_rd_data_i = 32'(i);
      sb.push_back('{a: 5'd7, d: 32'(i)});
    end
    next_cycle();
    alu_valid_i = 1'b0;
    @(negedge clk);
    total++; if (rs1_fwd_hit_o !== 1'b1) $display("FAIL fwd_hit got %b want 1", rs1_fwd_hit_o); else passed++;
    total++; if (rs1_fwd_data_o !== 32'd2) $display("FAIL fwd_data got %h want 2", rs1_fwd_data_o); else passed++;
    next_cycle();
    wb_stall_i = 1'b0;
    repeat (2) begin
      next_cycle();
      @(negedge clk);
      total++; if (rs1_fwd_data_o !== 32'd2) $display("FAIL fwd_drain got %h want 2", rs1_fwd_data_o); else passed++;
    end
    next_cycle();
    @(negedge clk);
    total++; if (rs1_fwd_hit_o !== 1'b0) $display("FAIL fwd_hit0 got %b want 0", rs1_fwd_hit_o); else passed++;
    total++; if (rs1_fwd_data_o !== 32'd0) $display("FAIL fwd_data0 got %h want 0", rs1_fwd_data_o); else passed++;
    rs1_addr_i = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_arb();
    test_full();
    test_x0_and_flush();
    test_random();
`ifdef REGFILE_WB_QUEUE_FWD_EN
    test_fwd();
`endif
    repeat (4) next_cycle();
    total++; if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
